// File: rtl/go_move_ctrl.sv
// Go board move controller: button-driven cursor, place/reject checking, board clear,
// and a registered display read port. Define GO_UNDO_EN to add single-level undo (btnl+btnr).
module go_move_ctrl #(
  parameter int         BOARD_N     = 9,
  parameter logic [1:0] STONE_BLACK = 2'b01
) (
  input  logic       vclock_in,
  input  logic       reset_n_in,
  input  logic       btnu_in,
  input  logic       btnd_in,
  input  logic       btnl_in,
  input  logic       btnr_in,
  input  logic       btnc_in,
  input  logic       clear_in,
  input  logic [3:0] rd_row_in,
  input  logic [3:0] rd_col_in,
  output logic [1:0] rd_stone_out,
  output logic [3:0] cursor_row_out,
  output logic [3:0] cursor_col_out,
  output logic [1:0] turn_out,
  output logic       move_ok_out,
  output logic       move_reject_out,
  output logic       busy_out
);

  localparam int         CELLS       = BOARD_N * BOARD_N;
  localparam int         IW          = $clog2(CELLS);
  localparam logic [1:0] STONE_WHITE = STONE_BLACK ^ 2'b11;
  localparam logic [3:0] MAX_POS     = 4'(BOARD_N - 1);
  localparam logic [4:0] SIDE        = 5'(BOARD_N);
  localparam logic [IW-1:0] LAST_CELL = IW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, CLEAR} state_t;

  // Button vector order: {clear, btnc, btnr, btnl, btnd, btnu}
  localparam int B_U = 0;
  localparam int B_D = 1;
  localparam int B_L = 2;
  localparam int B_R = 3;
  localparam int B_C = 4;
  localparam int B_CLR = 5;

  state_t        state_q, state_d;
  logic [5:0]    btn_prev_q, btn_prev_d;
  logic [5:0]    btn_edge;
  logic [3:0]    cursor_row_q, cursor_row_d;
  logic [3:0]    cursor_col_q, cursor_col_d;
  logic [1:0]    turn_q, turn_d;
  logic [IW-1:0] pos_idx_q, pos_idx_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          ok_q, ok_d;
  logic          reject_q, reject_d;
  logic [1:0]    rd_stone_q, rd_stone_d;
  logic [1:0]    board_q [CELLS];
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [1:0]    wr_data;
`ifdef GO_UNDO_EN
  logic [IW-1:0] last_idx_q, last_idx_d;
  logic          undo_valid_q, undo_valid_d;
`endif

  function automatic logic [IW-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return IW'(8'(row) * 8'(BOARD_N) + 8'(col));
  endfunction

  function automatic logic [1:0] other_stone(input logic [1:0] s);
    return (s == STONE_BLACK) ? STONE_WHITE : STONE_BLACK;
  endfunction

  always_comb begin
    btn_prev_d   = {clear_in, btnc_in, btnr_in, btnl_in, btnd_in, btnu_in};
    btn_edge     = btn_prev_d & ~btn_prev_q;
    state_d      = state_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    turn_d       = turn_q;
    pos_idx_d    = pos_idx_q;
    clr_cnt_d    = clr_cnt_q;
    ok_d         = 1'b0;
    reject_d     = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = pos_idx_q;
    wr_data      = turn_q;
`ifdef GO_UNDO_EN
    last_idx_d   = last_idx_q;
    undo_valid_d = undo_valid_q;
`endif

    // Edges seen outside IDLE fall through here and are simply lost.
    case (state_q)
      IDLE: begin
        if (btn_edge[B_CLR]) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
`ifdef GO_UNDO_EN
          undo_valid_d = 1'b0;
`endif
        end else if (btn_edge[B_C]) begin
          state_d   = CHECK;
          pos_idx_d = cell_idx(cursor_row_q, cursor_col_q);
        end
`ifdef GO_UNDO_EN
        else if (btn_edge[B_L] && btn_edge[B_R]) begin
          if (undo_valid_q) begin
            wr_en        = 1'b1;
            wr_idx       = last_idx_q;
            wr_data      = 2'b00;
            turn_d       = other_stone(turn_q);
            undo_valid_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end
`endif
        else begin
          if (btn_edge[B_U]) begin
            if (cursor_row_q != 4'd0) cursor_row_d = cursor_row_q - 4'd1;
          end else if (btn_edge[B_D]) begin
            if (cursor_row_q != MAX_POS) cursor_row_d = cursor_row_q + 4'd1;
          end
          if (btn_edge[B_L]) begin
            if (cursor_col_q != 4'd0) cursor_col_d = cursor_col_q - 4'd1;
          end else if (btn_edge[B_R]) begin
            if (cursor_col_q != MAX_POS) cursor_col_d = cursor_col_q + 4'd1;
          end
        end
      end
      CHECK: begin
        if (board_q[pos_idx_q] == 2'b00) begin
          state_d = WRITE;
        end else begin
          state_d  = IDLE;
          reject_d = 1'b1;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_idx  = pos_idx_q;
        wr_data = turn_q;
        turn_d  = other_stone(turn_q);
        ok_d    = 1'b1;
        state_d = IDLE;
`ifdef GO_UNDO_EN
        last_idx_d   = pos_idx_q;
        undo_valid_d = 1'b1;
`endif
      end
      CLEAR: begin
        wr_en     = 1'b1;
        wr_idx    = clr_cnt_q;
        wr_data   = 2'b00;
        clr_cnt_d = clr_cnt_q + IW'(1);
        if (clr_cnt_q == LAST_CELL) begin
          state_d      = IDLE;
          clr_cnt_d    = '0;
          turn_d       = STONE_BLACK;
          cursor_row_d = 4'd0;
          cursor_col_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Off-board addresses read as empty; the display may scan past the board edge.
    rd_stone_d = 2'b00;
    if (({1'b0, rd_row_in} < SIDE) && ({1'b0, rd_col_in} < SIDE))
      rd_stone_d = board_q[cell_idx(rd_row_in, rd_col_in)];
  end

  always_ff @(posedge vclock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q      <= IDLE;
      btn_prev_q   <= '0;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      turn_q       <= STONE_BLACK;
      pos_idx_q    <= '0;
      clr_cnt_q    <= '0;
      ok_q         <= 1'b0;
      reject_q     <= 1'b0;
      rd_stone_q   <= 2'b00;
      for (int i = 0; i < CELLS; i++) board_q[i] <= 2'b00;
`ifdef GO_UNDO_EN
      last_idx_q   <= '0;
      undo_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btn_prev_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      turn_q       <= turn_d;
      pos_idx_q    <= pos_idx_d;
      clr_cnt_q    <= clr_cnt_d;
      ok_q         <= ok_d;
      reject_q     <= reject_d;
      rd_stone_q   <= rd_stone_d;
      if (wr_en) board_q[wr_idx] <= wr_data;
`ifdef GO_UNDO_EN
      last_idx_q   <= last_idx_d;
      undo_valid_q <= undo_valid_d;
`endif
    end
  end

  assign rd_stone_out    = rd_stone_q;
  assign cursor_row_out  = cursor_row_q;
  assign cursor_col_out  = cursor_col_q;
  assign turn_out        = turn_q;
  assign move_ok_out     = ok_q;
  assign move_reject_out = reject_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_go_move_ctrl.sv
// Self-checking bench for go_move_ctrl: directed scenarios plus random button traffic
// compared against a board/cursor/turn model. Honours GO_UNDO_EN like the design.
module tb_go_move_ctrl;
  localparam int N     = 9;
  localparam int BLACK = 1;

  logic       vclock_in = 1'b0;
  logic       reset_n_in;
  logic       btnu_in, btnd_in, btnl_in, btnr_in, btnc_in, clear_in;
  logic [3:0] rd_row_in, rd_col_in;
  logic [1:0] rd_stone_out;
  logic [3:0] cursor_row_out, cursor_col_out;
  logic [1:0] turn_out;
  logic       move_ok_out, move_reject_out, busy_out;

  int checks = 0;
  int errors = 0;

  int mb [N][N];
  int cur_r, cur_c, turn;
  bit undo_valid;
  int undo_r, undo_c;

  go_move_ctrl dut (
    .vclock_in      (vclock_in),
    .reset_n_in     (reset_n_in),
    .btnu_in        (btnu_in),
    .btnd_in        (btnd_in),
    .btnl_in        (btnl_in),
    .btnr_in        (btnr_in),
    .btnc_in        (btnc_in),
    .clear_in       (clear_in),
    .rd_row_in      (rd_row_in),
    .rd_col_in      (rd_col_in),
    .rd_stone_out   (rd_stone_out),
    .cursor_row_out (cursor_row_out),
    .cursor_col_out (cursor_col_out),
    .turn_out       (turn_out),
    .move_ok_out    (move_ok_out),
    .move_reject_out(move_reject_out),
    .busy_out       (busy_out)
  );

  always #5 vclock_in = ~vclock_in;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mask = {clear, btnc, btnr, btnl, btnd, btnu}; held for exactly one rising clock edge
  task automatic applyStimulus(input logic [5:0] mask);
    {clear_in, btnc_in, btnr_in, btnl_in, btnd_in, btnu_in} = mask;
    @(negedge vclock_in);
    {clear_in, btnc_in, btnr_in, btnl_in, btnd_in, btnu_in} = '0;
  endtask

  task automatic modelReset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mb[r][c] = 0;
    cur_r = 0; cur_c = 0; turn = BLACK; undo_valid = 0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_row"}, cursor_row_out, cur_r);
    checkOutput({tag, "_col"}, cursor_col_out, cur_c);
    checkOutput({tag, "_turn"}, turn_out, turn);
    checkOutput({tag, "_busy"}, busy_out, 0);
  endtask

  task automatic checkRead(input int r, input int c);
    int exp;
    rd_row_in = 4'(r);
    rd_col_in = 4'(c);
    @(negedge vclock_in);
    exp = 0;
    if (r < N && c < N) exp = mb[r][c];
    checkOutput("read", rd_stone_out, exp);
  endtask

  task automatic runAction(input logic [5:0] mask);
    int n;
    int cnt;
    bit exp_ok;
    if (mask[5]) begin
      applyStimulus(mask);
      cnt = 0;
      while (busy_out === 1'b1 && cnt < 400) begin
        cnt++;
        @(negedge vclock_in);
      end
      checkOutput("clear_busy_cycles", cnt, N * N);
      modelReset();
      checkState("clear");
    end else if (mask[4]) begin
      exp_ok = (mb[cur_r][cur_c] == 0);
      applyStimulus(mask);
      n = 0;
      do begin
        @(negedge vclock_in);
        n++;
      end while (!move_ok_out && !move_reject_out && n < 8);
      checkOutput("place_ok", move_ok_out, exp_ok);
      checkOutput("place_rej", move_reject_out, !exp_ok);
      checkOutput("place_latency", n, exp_ok ? 2 : 1);
      @(negedge vclock_in);
      checkOutput("pulse_width", {move_ok_out, move_reject_out}, 0);
      if (exp_ok) begin
        mb[cur_r][cur_c] = turn;
        undo_r = cur_r; undo_c = cur_c; undo_valid = 1;
        turn = 3 - turn;
      end
      checkState("place");
    end
`ifdef GO_UNDO_EN
    else if (mask[2] && mask[3]) begin
      applyStimulus(mask);
      checkOutput("undo_rej", move_reject_out, !undo_valid);
      checkOutput("undo_ok_low", move_ok_out, 0);
      if (undo_valid) begin
        mb[undo_r][undo_c] = 0;
        turn = 3 - turn;
        undo_valid = 0;
      end
      @(negedge vclock_in);
      checkOutput("undo_pulse_width", move_reject_out, 0);
      checkState("undo");
    end
`endif
    else begin
      applyStimulus(mask);
      if (mask[0]) cur_r = (cur_r > 0) ? cur_r - 1 : 0;
      else if (mask[1]) cur_r = (cur_r < N - 1) ? cur_r + 1 : N - 1;
      if (mask[2]) cur_c = (cur_c > 0) ? cur_c - 1 : 0;
      else if (mask[3]) cur_c = (cur_c < N - 1) ? cur_c + 1 : N - 1;
      checkState("move");
    end
    @(negedge vclock_in);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [5:0] mask;
    int sel;
    reset_n_in = 1'b0;
    {clear_in, btnc_in, btnr_in, btnl_in, btnd_in, btnu_in} = '0;
    rd_row_in = '0;
    rd_col_in = '0;
    modelReset();
    repeat (3) @(negedge vclock_in);
    checkState("reset");
    checkOutput("reset_ok", move_ok_out, 0);
    checkOutput("reset_rej", move_reject_out, 0);
    checkOutput("reset_rd", rd_stone_out, 0);
    reset_n_in = 1'b1;
    @(negedge vclock_in);

    // Saturation at the far corner, then both axes together back to the origin
    repeat (9) runAction(6'b001000);
    repeat (9) runAction(6'b000010);
    checkOutput("corner_row", cursor_row_out, 8);
    checkOutput("corner_col", cursor_col_out, 8);
    repeat (10) runAction(6'b000101);
    runAction(6'b000011);

    // Place at (3,4), then a rejected second placement on the same cell
    repeat (3) runAction(6'b000010);
    repeat (4) runAction(6'b001000);
    runAction(6'b010000);
    checkRead(3, 4);
    checkOutput("after_place_turn", turn_out, 2);
    runAction(6'b010000);
    checkRead(3, 4);
    checkOutput("after_reject_turn", turn_out, 2);

    // btnl+btnr together: left move, or undo when the feature is built in
    runAction(6'b001100);
    checkRead(3, 4);
    runAction(6'b001100);
    checkRead(3, 4);

    // Button edge arriving mid-placement is dropped
    repeat (9) runAction(6'b000101);
    repeat (6) runAction(6'b001010);
    applyStimulus(6'b010000);
    applyStimulus(6'b001000);
    @(negedge vclock_in);
    checkOutput("drop_ok", move_ok_out, 1);
    mb[cur_r][cur_c] = turn;
    undo_r = cur_r; undo_c = cur_c; undo_valid = 1;
    turn = 3 - turn;
    @(negedge vclock_in);
    checkState("drop");

    // A held level moves only once
    btnr_in = 1'b1;
    repeat (5) @(negedge vclock_in);
    btnr_in = 1'b0;
    cur_c = cur_c + 1;
    checkState("held");
    @(negedge vclock_in);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2)       mask = {2'b10, 4'($urandom_range(0, 15))};
      else if (sel < 30) mask = {2'b01, 4'($urandom_range(0, 15))};
      else               mask = {2'b00, 4'($urandom_range(1, 15))};
      runAction(mask);
      sel = $urandom_range(0, 3);
      if (sel == 0)      checkRead($urandom_range(0, 15), $urandom_range(0, 15));
      else if (sel == 1) checkRead($urandom_range(0, N - 1), $urandom_range(0, N - 1));
      else if (sel == 2) checkRead(cur_r, cur_c);
    end

    // Clear after a few stones, then sweep the whole board
    runAction(6'b010000);
    runAction(6'b001010);
    runAction(6'b010000);
    runAction(6'b001010);
    runAction(6'b010000);
    runAction(6'b100000);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) checkRead(r, c);

    // Reset asserted in the middle of a clear
    repeat (9) runAction(6'b001010);
    runAction(6'b010000);
    runAction(6'b000101);
    runAction(6'b010000);
    checkRead(8, 8);
    checkRead(7, 7);
    applyStimulus(6'b100000);
    repeat (40) @(negedge vclock_in);
    checkOutput("midclear_busy_before", busy_out, 1);
    reset_n_in = 1'b0;
    #1;
    modelReset();
    checkOutput("midclear_busy", busy_out, 0);
    checkOutput("midclear_turn", turn_out, BLACK);
    checkOutput("midclear_row", cursor_row_out, 0);
    checkOutput("midclear_col", cursor_col_out, 0);
    @(negedge vclock_in);
    reset_n_in = 1'b1;
    @(negedge vclock_in);
    checkState("post_reset");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) checkRead(r, c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/go_move_ctrl.md
GO_MOVE_CTRL -- requirements
Module: go_move_ctrl

Interface
REQ-001 SHALL have parameter BOARD_N, default 9, meaning board side length in intersections (legal range 2..15).
REQ-002 SHALL have parameter STONE_BLACK, default 2'b01, meaning the code for a black stone; white is 2'b10 and empty is 2'b00.
REQ-003 SHALL have port vclock_in, input, 1, 65MHz system clock.
REQ-004 SHALL have port reset_n_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports btnu_in, btnd_in, btnl_in, btnr_in, btnc_in, clear_in, all input, 1, debounced level buttons.
REQ-006 SHALL have ports rd_row_in and rd_col_in, input, 4 each, display read address.
REQ-007 SHALL have port rd_stone_out, output, 2, stone at the read address.
REQ-008 SHALL have ports cursor_row_out and cursor_col_out, output, 4 each, cursor position.
REQ-009 SHALL have port turn_out, output, 2, stone code of the player to move.
REQ-010 SHALL have ports move_ok_out and move_reject_out, output, 1 each, single-cycle result pulses.
REQ-011 SHALL have port busy_out, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL detect rising edges of every button using a registered previous value; a held level acts once.
REQ-013 SHALL store BOARD_N x BOARD_N 2-bit cells internally; the display reads through a port, and only this block writes.
REQ-014 SHALL register rd_stone_out one cycle after the address (latency 1); a row or column >= BOARD_N returns 2'b00.
REQ-015 SHALL use FSM states IDLE, CHECK, WRITE, CLEAR.
REQ-016 SHALL, in IDLE, choose one action per cycle by priority clear > place (btnc) > undo > cursor move.
REQ-017 SHALL move the cursor only in IDLE: btnu decrements the row, btnd increments it, btnl decrements the column, btnr increments it.
REQ-018 SHALL saturate cursor moves at 0 and BOARD_N-1, with no wrap.
REQ-019 SHALL give btnu priority over btnd and btnl priority over btnr on simultaneous edges; a vertical and a horizontal move in the same cycle SHALL both apply.
REQ-020 SHALL, on a place edge: IDLE -> CHECK, latching the cursor position; CHECK reads the cell.
REQ-021 SHALL, if the CHECK cell is empty, go CHECK -> WRITE.
REQ-022 SHALL, if the CHECK cell is occupied, go CHECK -> IDLE and pulse move_reject_out for 1 cycle.
REQ-023 SHALL, in WRITE, write turn_out to the cell, toggle turn, pulse move_ok_out, and return to IDLE; place-to-move_ok latency is exactly 2 cycles.
REQ-024 SHALL, on a clear edge: IDLE -> CLEAR, and a counter SHALL zero one cell per cycle for BOARD_N*BOARD_N cycles.
REQ-025 SHALL, on exit from CLEAR, set turn to black, return the cursor to (0,0), and return to IDLE.
REQ-026 SHALL drop button edges arriving while busy_out is high; they are not queued.
REQ-027 SHALL keep display reads functional in every state; during CLEAR a read returns the current cell contents.
REQ-028 SHALL hold move_ok_out and move_reject_out low outside their pulse cycles.

Reset
REQ-029 SHALL, on reset_n_in low and asynchronously, force state=IDLE, all cells=2'b00, turn_out=STONE_BLACK, cursor=(0,0), rd_stone_out=0, both pulses=0, busy_out=0, and edge registers=0.
REQ-030 SHALL abort a CLEAR or WRITE in progress when reset is asserted mid-operation, with no partial-state residue after deassertion.
REQ-031 SHALL deassert reset synchronously to vclock_in; this is guaranteed externally.

Configuration
REQ-032 SHALL, when GO_UNDO_EN is defined, record the last successful move position, and a btnl+btnr simultaneous edge in IDLE (undo) SHALL clear that cell, toggle turn back, and invalidate the record; undo with no valid record SHALL pulse move_reject_out.
REQ-033 SHALL, when GO_UNDO_EN is undefined, have no undo logic, and btnl+btnr together SHALL act only as a left move (REQ-019).
REQ-034 SHALL invalidate the undo record on CLEAR and on reset.

Verification
REQ-035 SHALL be verified by: reset, 9 btnr edges plus 9 btnd edges -> cursor=(8,8), with no wrap.
REQ-036 SHALL be verified by: cursor (3,4), btnc -> move_ok 2 cycles later; read (3,4) -> 2'b01 next cycle; turn_out=2'b10.
REQ-037 SHALL be verified by: btnc again at (3,4) -> move_reject pulse, cell stays 01, turn stays 10.
REQ-038 SHALL be verified by: clear edge after 3 moves -> busy_out high for exactly 81 cycles; all reads 00, turn 01, cursor (0,0).
REQ-039 SHALL be verified by: reset_n_in low for 1 cycle at clear cycle 40 -> immediate IDLE, all cells 00, busy_out 0.
REQ-040 SHALL be verified by: with GO_UNDO_EN, place at (2,2), then btnl+btnr -> (2,2) reads 00, turn 01; a second undo -> move_reject.
